// File: rtl/input_debouncer.sv
// Per-channel switch debouncer: stable levels, one-cycle rise/fall pulses,
// and sticky press-pending / overrun flags acknowledged by the CPU side.
module input_debouncer #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in,
  input  logic [WIDTH-1:0] ack,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] pending,
  output logic [WIDTH-1:0] overrun
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] accept_c;
  logic [WIDTH-1:0] press_c;

  // A channel accepts its new value on the edge where the count has matured.
  always_comb begin
    accept_c = '0;
    press_c  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      accept_c[i] = (in[i] != level[i]) && (cnt[i] == CNT_MAX);
      press_c[i]  = accept_c[i] && in[i];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
      level   <= '0;
      rise    <= '0;
      fall    <= '0;
      pending <= '0;
      overrun <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (in[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (accept_c[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
      level   <= (level & ~accept_c) | (in & accept_c);
      rise    <= press_c;
      fall    <= accept_c & ~in;
      // A press coinciding with ack wins, so no event is ever dropped.
      pending <= press_c | (pending & ~ack);
      overrun <= (press_c & pending & ~ack) | (overrun & ~ack);
    end
  end

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer (WIDTH=4, DEBOUNCE_CYCLES=4) with an
// expectation queue filled at drive time and drained after each clock edge.
module tb_input_debouncer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] in_r;
  logic [3:0] ack_r;
  logic [3:0] level, rise, fall, pending, overrun;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      tag;
    logic [3:0] lvl;
    logic [3:0] ris;
    logic [3:0] fal;
    logic [3:0] pnd;
    logic [3:0] ovr;
  } exp_t;

  exp_t sb[$];

  input_debouncer #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .in      (in_r),
    .ack     (ack_r),
    .level   (level),
    .rise    (rise),
    .fall    (fall),
    .pending (pending),
    .overrun (overrun)
  );

  always #5 clock = ~clock;

  task automatic step(input string tag, input logic [3:0] l, input logic [3:0] r,
                      input logic [3:0] f, input logic [3:0] p, input logic [3:0] o);
    exp_t e;
    logic [19:0] obs, expv;
    e.tag = tag; e.lvl = l; e.ris = r; e.fal = f; e.pnd = p; e.ovr = o;
    sb.push_back(e);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    obs  = {level, rise, fall, pending, overrun};
    expv = {e.lvl, e.ris, e.fal, e.pnd, e.ovr};
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed lvl=%h rise=%h fall=%h pend=%h ovr=%h expected lvl=%h rise=%h fall=%h pend=%h ovr=%h",
             e.tag, level, rise, fall, pending, overrun, e.lvl, e.ris, e.fal, e.pnd, e.ovr);
    end
  endtask

  task automatic hold(input int n, input string tag, input logic [3:0] l, input logic [3:0] r,
                      input logic [3:0] f, input logic [3:0] p, input logic [3:0] o);
    for (int k = 0; k < n; k++) step(tag, l, r, f, p, o);
  endtask

  initial begin
    reset_n = 1'b0; in_r = 4'hF; ack_r = 4'h0;

    // Reset holds everything at zero even with inputs high
    hold(3, "reset", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    reset_n = 1'b1;
    hold(3, "post_reset_count", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    step("post_reset_rise", 4'hF, 4'hF, 4'h0, 4'hF, 4'h0);
    step("post_reset_settle", 4'hF, 4'h0, 4'h0, 4'hF, 4'h0);
    ack_r = 4'hF;
    step("ack_all", 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
    ack_r = 4'h0;

    // Bring ch0 low so glitch rejection starts from level 0
    in_r = 4'hE;
    hold(3, "ch0_drop_count", 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
    step("ch0_drop", 4'hE, 4'h0, 4'h1, 4'h0, 4'h0);

    // 3-cycle glitch must not reach level
    in_r = 4'hF;
    hold(3, "glitch_high", 4'hE, 4'h0, 4'h0, 4'h0, 4'h0);
    in_r = 4'hE;
    step("glitch_end", 4'hE, 4'h0, 4'h0, 4'h0, 4'h0);
    in_r = 4'hF;
    hold(3, "ch0_press_count", 4'hE, 4'h0, 4'h0, 4'h0, 4'h0);
    step("ch0_press", 4'hF, 4'h1, 4'h0, 4'h1, 4'h0);
    step("ch0_press_settle", 4'hF, 4'h0, 4'h0, 4'h1, 4'h0);

    // Release on ch1 pulses fall only
    in_r = 4'hD;
    hold(3, "ch1_release_count", 4'hF, 4'h0, 4'h0, 4'h1, 4'h0);
    step("ch1_release", 4'hD, 4'h0, 4'h2, 4'h1, 4'h0);
    step("ch1_release_settle", 4'hD, 4'h0, 4'h0, 4'h1, 4'h0);

    // ch2: press, press again unacknowledged -> overrun, then ack clears both
    in_r = 4'h9;
    hold(3, "ch2_drop_count", 4'hD, 4'h0, 4'h0, 4'h1, 4'h0);
    step("ch2_drop", 4'h9, 4'h0, 4'h4, 4'h1, 4'h0);
    in_r = 4'hD;
    hold(3, "ch2_press1_count", 4'h9, 4'h0, 4'h0, 4'h1, 4'h0);
    step("ch2_press1", 4'hD, 4'h4, 4'h0, 4'h5, 4'h0);
    in_r = 4'h9;
    hold(3, "ch2_drop2_count", 4'hD, 4'h0, 4'h0, 4'h5, 4'h0);
    step("ch2_drop2", 4'h9, 4'h0, 4'h4, 4'h5, 4'h0);
    in_r = 4'hD;
    hold(3, "ch2_press2_count", 4'h9, 4'h0, 4'h0, 4'h5, 4'h0);
    step("ch2_overrun", 4'hD, 4'h4, 4'h0, 4'h5, 4'h4);
    ack_r = 4'h4;
    step("ch2_ack", 4'hD, 4'h0, 4'h0, 4'h1, 4'h0);
    ack_r = 4'h0;

    // ch3: press with ack in the same cycle keeps pending, no overrun
    in_r = 4'h5;
    hold(3, "ch3_drop_count", 4'hD, 4'h0, 4'h0, 4'h1, 4'h0);
    step("ch3_drop", 4'h5, 4'h0, 4'h8, 4'h1, 4'h0);
    in_r = 4'hD;
    hold(3, "ch3_press1_count", 4'h5, 4'h0, 4'h0, 4'h1, 4'h0);
    step("ch3_press1", 4'hD, 4'h8, 4'h0, 4'h9, 4'h0);
    in_r = 4'h5;
    hold(3, "ch3_drop2_count", 4'hD, 4'h0, 4'h0, 4'h9, 4'h0);
    step("ch3_drop2", 4'h5, 4'h0, 4'h8, 4'h9, 4'h0);
    in_r = 4'hD;
    hold(3, "ch3_press2_count", 4'h5, 4'h0, 4'h0, 4'h9, 4'h0);
    ack_r = 4'h8;
    step("ch3_press_ack", 4'hD, 4'h8, 4'h0, 4'h9, 4'h0);
    ack_r = 4'h0;
    step("ch3_press_ack_settle", 4'hD, 4'h0, 4'h0, 4'h9, 4'h0);

    // Ack on a channel with nothing pending changes nothing
    ack_r = 4'h2;
    step("ack_idle_ch1", 4'hD, 4'h0, 4'h0, 4'h9, 4'h0);
    ack_r = 4'h0;

    // Reset in the middle of a count discards the partial count
    in_r = 4'hC;
    hold(3, "ch0_drop2_count", 4'hD, 4'h0, 4'h0, 4'h9, 4'h0);
    step("ch0_drop2", 4'hC, 4'h0, 4'h1, 4'h9, 4'h0);
    in_r = 4'hD;
    hold(3, "mid_count", 4'hC, 4'h0, 4'h0, 4'h9, 4'h0);
    reset_n = 1'b0;
    step("mid_reset", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    reset_n = 1'b1;
    hold(3, "recount", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    step("recount_rise", 4'hD, 4'hD, 4'h0, 4'hD, 4'h0);
    step("recount_settle", 4'hD, 4'h0, 4'h0, 4'hD, 4'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
